// File: rtl/imem_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : imem_access_arbiter
// Description : Shares a single-port synchronous-read instruction memory
//               between the fetch unit and the program loader. Optional
//               address-fault handling is enabled by the IMEM_FAULT_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_access_arbiter #(
    parameter int InstLength   = 256,
    parameter int STARVE_LIMIT = 4,
    localparam int AW          = $clog2(InstLength)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_done_i,
    input  logic          fetch_req_i,
    input  logic [31:0]   fetch_addr_i,
    output logic          fetch_gnt_o,
    output logic          fetch_rvalid_o,
    output logic [31:0]   fetch_rdata_o,
`ifdef IMEM_FAULT_EN
    output logic          fetch_fault_o,
`endif
    input  logic          load_req_i,
    input  logic          load_we_i,
    input  logic [31:0]   load_addr_i,
    input  logic [31:0]   load_wdata_i,
    output logic          load_gnt_o,
    output logic          load_rvalid_o,
    output logic [31:0]   load_rdata_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    input  logic [31:0]   mem_rdata_i
);

    localparam int            SW         = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [0:0] {ST_BOOT, ST_RUN} state_e;
    typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_LOAD} owner_e;

    state_e        state_q, state_d;
    owner_e        owner_q, owner_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [31:0]   fetch_rdata_q, load_rdata_q;

    logic          fetch_win, load_win, any_win;
    logic [31:0]   sel_addr;
    logic          sel_fault;
    logic [31:0]   rd_word;

    // Grants are forced low while reset is asserted so outputs read as idle.
    always_comb begin
        fetch_win = 1'b0;
        load_win  = 1'b0;
        state_d   = state_q;
        if (!rst) begin
            case (state_q)
                ST_BOOT: begin
                    load_win = load_req_i;
                    if (load_done_i) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (fetch_req_i && load_req_i) begin
                        if (starve_q == STARVE_MAX) begin
                            load_win = 1'b1;
                        end else begin
                            fetch_win = 1'b1;
                        end
                    end else begin
                        fetch_win = fetch_req_i;
                        load_win  = load_req_i;
                    end
                end
                default: state_d = ST_BOOT;
            endcase
        end
    end

    always_comb begin
        starve_d = '0;
        if (load_req_i && !load_win) begin
            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 1'b1;
        end
    end

    assign any_win  = fetch_win | load_win;
    assign sel_addr = fetch_win ? fetch_addr_i : load_addr_i;

`ifdef IMEM_FAULT_EN
    logic fault_q, fault_d;

    assign sel_fault = any_win &&
                       ((sel_addr[1:0] != 2'b00) ||
                        ({2'b00, sel_addr[31:2]} >= 32'(InstLength)));
    // A faulting loader write is simply dropped and produces no read-back.
    assign fault_d   = sel_fault && (owner_d != OWN_NONE);
    assign rd_word   = fault_q ? 32'h0000_0013 : mem_rdata_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign fetch_fault_o = fetch_rvalid_o & fault_q;
`else
    logic unused_addr_bits;

    assign sel_fault        = 1'b0;
    assign rd_word          = mem_rdata_i;
    assign unused_addr_bits = ^{sel_addr[31:AW+2], sel_addr[1:0]};
`endif

    assign owner_d = fetch_win                ? OWN_FETCH :
                     (load_win && !load_we_i) ? OWN_LOAD  : OWN_NONE;

    assign fetch_gnt_o = fetch_win;
    assign load_gnt_o  = load_win;
    assign mem_en_o    = any_win & ~sel_fault;
    assign mem_we_o    = load_win & load_we_i & ~sel_fault;
    assign mem_addr_o  = any_win ? sel_addr[AW+1:2] : '0;
    assign mem_wdata_o = (load_win && load_we_i) ? load_wdata_i : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_BOOT;
            owner_q       <= OWN_NONE;
            starve_q      <= '0;
            fetch_rdata_q <= '0;
            load_rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
            if (owner_q == OWN_FETCH) begin
                fetch_rdata_q <= rd_word;
            end
            if (owner_q == OWN_LOAD) begin
                load_rdata_q <= rd_word;
            end
        end
    end

    // Read data passes straight through on the valid cycle, then is held.
    assign fetch_rvalid_o = (owner_q == OWN_FETCH);
    assign load_rvalid_o  = (owner_q == OWN_LOAD);
    assign fetch_rdata_o  = fetch_rvalid_o ? rd_word : fetch_rdata_q;
    assign load_rdata_o   = load_rvalid_o  ? rd_word : load_rdata_q;

endmodule
`default_nettype wire
